pu_ctrl: RTL

PU_CTRL -- requirements
Module: pu_ctrl

---
 rtl/pu_ctrl_if.sv | 35 +++
 rtl/pu_ctrl.sv | 103 ++++++++++
 2 files changed

// File: rtl/pu_ctrl_if.sv
// pu_ctrl_if -- the bus between a host/PU datapath and the pu_ctrl sequencer.
//   master : host side; drives start, n_neurons and hold, and observes the rest
//   slave  : pu_ctrl side
//   start      one-cycle run request
//   n_neurons  neuron count for the run (ADDR_W+1 bits, clamped by pu_ctrl)
//   hold       suppresses new issues
//   rd_addr    operand/weight set index presented to the PU
//   issue      rd_addr is a real issue this cycle
//   out_we     PU output valid this cycle
//   out_addr   neuron index of the PU output
//   busy       high in every state except IDLE
//   done       one-cycle pulse at run completion
interface pu_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              start;
    logic [ADDR_W:0]   n_neurons;
    logic              hold;
    logic [ADDR_W-1:0] rd_addr;
    logic              issue;
    logic              out_we;
    logic [ADDR_W-1:0] out_addr;
    logic              busy;
    logic              done;

    modport master (
        output start, n_neurons, hold,
        input  rd_addr, issue, out_we, out_addr, busy, done
    );

    modport slave (
        input  start, n_neurons, hold,
        output rd_addr, issue, out_we, out_addr, busy, done
    );
endinterface

// File: rtl/pu_ctrl.sv
// pu_ctrl -- sequences one run over up to 2^ADDR_W neurons through a
// fixed-latency processing unit (PU). Operand indices are issued in ascending
// order, a PU_LAT-deep valid/index pipeline mirrors the PU so that the write
// strobe lines up with the PU result, and done pulses once every result is out.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pu_ctrl_if.slave (start/n_neurons/hold in; rd_addr/issue/
//                out_we/out_addr/busy/done out)
//   cycle_cnt  : 16-bit saturating busy-cycle counter, present only when the
//                macro PU_CTRL_PERF_EN is defined
module pu_ctrl #(
    parameter int ADDR_W = 4,
    parameter int PU_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    pu_ctrl_if.slave    bus
`ifdef PU_CTRL_PERF_EN
    ,
    output logic [15:0] cycle_cnt
`endif
);
    localparam logic [ADDR_W:0] N_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                        state, state_nxt;
    logic [ADDR_W:0]               n_eff, n_clamp;
    logic [ADDR_W-1:0]             idx, last_addr;
    logic                          issue, last_issue;
    logic [PU_LAT:1]               vld_pipe;
    logic [PU_LAT:1][ADDR_W-1:0]   addr_pipe;
    logic [PU_LAT:0]               vld_all;

    // Oversized counts clamp to the table size instead of wrapping.
    assign n_clamp    = (bus.n_neurons > N_MAX) ? N_MAX : bus.n_neurons;
    assign last_issue = issue && ({1'b0, idx} == n_eff - (ADDR_W+1)'(1));
    // Stage 0 is this cycle's issue; stages 1..PU_LAT are registered.
    assign vld_all    = {vld_pipe, issue};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        bus.busy  = (state != IDLE);
        bus.done  = 1'b0;
        case (state)
            IDLE:  if (bus.start) state_nxt = (n_clamp == '0) ? DONE : ISSUE;
            ISSUE: begin
                issue = !bus.hold;
                if (last_issue) state_nxt = DRAIN;
            end
            // Leave once nothing would remain valid after this edge's shift,
            // i.e. the final out_we is happening now (or already happened).
            DRAIN: if (vld_all[PU_LAT-1:0] == '0) state_nxt = DONE;
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_eff     <= '0;
            idx       <= '0;
            last_addr <= '0;
            vld_pipe  <= '0;
            addr_pipe <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                n_eff <= n_clamp;
                idx   <= '0;
            end
            if (issue) begin
                idx       <= idx + ADDR_W'(1);
                last_addr <= idx;
            end
            // The PU has no stall, so this mirror shifts every cycle.
            vld_pipe     <= vld_all[PU_LAT-1:0];
            addr_pipe[1] <= idx;
            for (int i = 2; i <= PU_LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
        end
    end

    // While held, rd_addr keeps showing the last issued index.
    assign bus.issue    = issue;
    assign bus.rd_addr  = issue ? idx : last_addr;
    assign bus.out_we   = vld_pipe[PU_LAT];
    assign bus.out_addr = addr_pipe[PU_LAT];

`ifdef PU_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               cycle_cnt <= '0;
        else if (state == IDLE && bus.start)      cycle_cnt <= '0;
        else if (bus.busy && cycle_cnt != 16'hFFFF) cycle_cnt <= cycle_cnt + 16'd1;
    end
`endif
endmodule
